resta_nibble_serial: RTL and testbench
======================================

Name: resta_nibble_serial

Overview:
Sequential W-bit subtractor that computes a - b - bin one nibble per clock, LSB nibble first, and propagates a borrow between nibbles. It is the subtract-direction counterpart of the combinational nibble adder in the CPU datapath. The ALU uses it for multi-nibble SUB/CMP through a start/busy/done handshake. Results are also checkable against the nibble adder via the identity a - b - bin = a + ~b + ~bin, with bout = ~carry.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIB, WIDTH/4 (derived localparam), number of nibble steps per operation

Ports:
clk    input   1      system clock, rising edge
rst_n  input   1      asynchronous reset, active-low
start  input   1      request; sampled only when busy=0
a      input   WIDTH  minuend; sampled on the accepted start edge
b      input   WIDTH  subtrahend; sampled on the accepted start edge
bin    input   1      borrow in; sampled on the accepted start edge
busy   output  1      operation in progress
done   output  1      one-cycle pulse when the result becomes valid
d      output  WIDTH  difference; updated only at completion
bout   output  1      borrow out of the MSB nibble (1 = a < b + bin, unsigned)
zero   output  1      d == 0
ovf    output  1      signed two's-complement overflow

Behaviour:
- Reset (rst_n=0, async):
  - State goes to IDLE.
  - busy=0, done=0, d=0, bout=0, zero=0, ovf=0.
  - Internal operand registers, working register, borrow and index are all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, with start=1 at a rising edge:
  - Latch a, b and bin.
  - Set idx=0, borrow=bin.
  - Go to RUN.
- IDLE or DONE, with start=0: go to / stay in IDLE.
- DONE always lasts exactly one cycle.
- RUN, each edge:
  - Compute t = {1'b0, a_nib[idx]} - {1'b0, b_nib[idx]} - borrow (5-bit).
  - Write the nibble t[3:0] into working slot idx.
  - Set borrow = t[4], then idx = idx + 1.
  - On the edge that processes idx = NIB-1:
    - Copy the working register to d and set bout = final borrow.
    - Set zero = (result == 0).
    - Set ovf = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]), using the latched operands.
    - Go to DONE.
- Outputs by state:
  - busy=1 exactly in RUN.
  - done=1 exactly in DONE.
- Latency:
  - An accepted start at edge E0 puts done high in the cycle after edge E0+NIB.
  - busy is high for NIB cycles.
  - WIDTH=16 gives 4 cycles; WIDTH=4 gives 1 cycle.
- d, bout, zero and ovf hold their last completed values through IDLE and the following RUN. They change only at completion or reset.
- start while busy=1 is ignored; it is not queued and has no side effects.
- start during the DONE cycle is accepted, giving back-to-back operation with no idle cycle.
- Input changes on a, b or bin after acceptance have no effect on the operation in progress.
- bin affects only nibble 0. No carry-chain shortcut: exactly NIB steps every time, even for zero operands.
- rst_n deassertion mid-RUN aborts the operation. No done pulse is produced, and outputs return to their reset values.

Test Plan:
1. WIDTH=16: 0x1234 - 0x0234, bin=0 → done exactly 4 cycles after the start edge; d=0x1000, bout=0, zero=0, ovf=0; busy high for 4 cycles.
2. Borrow and overflow cases:
   - 0x0000 - 0x0001, bin=0 → d=0xFFFF, bout=1, ovf=0.
   - 0x8000 - 0x0001 → d=0x7FFF, bout=0, ovf=1.
   - 0x5555 - 0x5554, bin=1 → d=0x0000, zero=1, bout=0.
3. Handshake:
   - Pulse start again during RUN with different operands → ignored; result matches the first operation.
   - Start held during the DONE cycle → second operation begins immediately; its done arrives 4 cycles later.
   - d is unchanged during the second RUN.
4. Reset mid-operation: assert rst_n=0 asynchronously (between edges) at cycle 2 of RUN → busy, done, d and flags are 0 immediately; no done pulse afterwards; the next start completes normally.
5. WIDTH=4, exhaustive over all a, b and bin (512 cases) → for each: d == (a + ~b + ~bin) mod 16 and bout == ~c4, where c4 comes from the nibble adder driven with b inverted and c0=~bin.
6. Random regression, WIDTH=16, 1000 operations with random start gaps (0-3 idle cycles) → {bout, d} == {1'b0, a} - b - bin, plus matching zero and ovf for every operation.

Source files
------------

// File: rtl/resta_nibble_serial.sv
// Nibble-serial W-bit subtractor: computes a - b - bin one nibble per clock, LSB first,
// with a start/busy/done handshake and registered result flags.
module resta_nibble_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, work, work_next;
    logic             borrow;
    logic [IW-1:0]    idx;
    logic [3:0]       a_nib, b_nib;
    logic [4:0]       t;
    logic             last;
    logic             accept;

    assign accept = (state != S_RUN) && start;
    assign last   = (idx == IW'(NIB - 1));
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    // One nibble step; bit 4 of the 5-bit difference is the borrow into the next nibble.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        work_next = work;
        a_nib     = a_q[{idx, 2'b00} +: 4];
        b_nib     = b_q[{idx, 2'b00} +: 4];
        t         = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow};
        work_next[{idx, 2'b00} +: 4] = t[3:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: state_next = start ? S_RUN : S_IDLE;
            S_RUN:          if (last) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so all flops see pre-edge values.
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            work   <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            idx    <= '0;
        end else if (state == S_RUN) begin
            work   <= work_next;
            borrow <= t[4];
            idx    <= idx + IW'(1);
            // Result and flags are published only on the final nibble.
            if (last) begin
                d    <= work_next;
                bout <= t[4];
                zero <= (work_next == '0);
                ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_next[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_resta_nibble_serial.sv
// Directed and regression bench for resta_nibble_serial at WIDTH=16 and WIDTH=4.
module tb_resta_nibble_serial;

    logic clk = 1'b0;
    logic rst_n;

    logic        start16, bin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, bout16, zero16, ovf16;
    logic [15:0] d16;

    logic        start4, bin4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, bout4, zero4, ovf4;
    logic [3:0]  d4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    resta_nibble_serial #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .d(d16), .bout(bout16), .zero(zero16), .ovf(ovf16)
    );

    resta_nibble_serial #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4), .zero(zero4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle or in DONE; returns at the negedge of the DONE cycle.
    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                        input logic chk_hold, input logic [15:0] hold_d,
                        output int nbusy, output logic got_done, output logic hold_ok);
        start16 = 1'b1; a16 = ta; b16 = tb_v; bin16 = tbin;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        nbusy = 0; got_done = 1'b0; hold_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done16) begin
                got_done = 1'b1;
                break;
            end
            if (busy16) nbusy++;
            if (chk_hold && busy16 && d16 !== hold_d) hold_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic expect16(input string tag, input logic got_done, input int nbusy,
                            input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
        check({tag, ".done"}, {31'd0, got_done}, 32'd1);
        check({tag, ".busy_cycles"}, nbusy, 32'd4);
        check({tag, ".d"}, {16'd0, d16}, {16'd0, ed});
        check({tag, ".bout"}, {31'd0, bout16}, {31'd0, eb});
        check({tag, ".zero"}, {31'd0, zero16}, {31'd0, ez});
        check({tag, ".ovf"}, {31'd0, ovf16}, {31'd0, eo});
    endtask

    function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y, input logic c0);
        return {1'b0, x} + {1'b0, y} + {4'd0, c0};
    endfunction

    initial begin
        int          nb;
        logic        gd, hk;
        logic [16:0] m;
        logic [15:0] ra, rb;
        logic        rbin, eo;
        logic [4:0]  s;
        int          gap, ndone, w;

        rst_n = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        start4 = 1'b0;  a4 = '0;  b4 = '0;  bin4 = 1'b0;

        #3;
        check("reset.busy", {31'd0, busy16}, 32'd0);
        check("reset.done", {31'd0, done16}, 32'd0);
        check("reset.d", {16'd0, d16}, 32'd0);
        check("reset.flags", {29'd0, bout16, zero16, ovf16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: basic latency and result.
        op16(16'h1234, 16'h0234, 1'b0, 1'b0, 16'h0, nb, gd, hk);
        expect16("t1", gd, nb, 16'h1000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1.idle_after", {30'd0, busy16, done16}, 32'd0);

        // Test 2: borrow, overflow and zero cases.
        op16(16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0, nb, gd, hk);
        expect16("t2a", gd, nb, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        op16(16'h8000, 16'h0001, 1'b0, 1'b0, 16'h0, nb, gd, hk);
        expect16("t2b", gd, nb, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        op16(16'h5555, 16'h5554, 1'b1, 1'b0, 16'h0, nb, gd, hk);
        expect16("t2c", gd, nb, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // Test 3a: start during RUN is ignored and not queued.
        start16 = 1'b1; a16 = 16'h00FF; b16 = 16'h0F00; bin16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0001; bin16 = 1'b1;
        check("t3a.zero_held", {31'd0, zero16}, 32'd1);
        @(negedge clk);
        start16 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12 && !done16; i++) @(negedge clk);
        check("t3a.done", {31'd0, done16}, 32'd1);
        check("t3a.d", {16'd0, d16}, 32'h0000F1FF);
        check("t3a.bout", {31'd0, bout16}, 32'd1);
        @(negedge clk);
        check("t3a.not_queued", {31'd0, busy16}, 32'd0);

        // Test 3b: back-to-back with start in the DONE cycle; d holds during the second RUN.
        op16(16'h4000, 16'h1000, 1'b0, 1'b0, 16'h0, nb, gd, hk);
        expect16("t3b.first", gd, nb, 16'h3000, 1'b0, 1'b0, 1'b0);
        op16(16'h7000, 16'hF000, 1'b1, 1'b1, 16'h3000, nb, gd, hk);
        check("t3b.d_hold", {31'd0, hk}, 32'd1);
        expect16("t3b.second", gd, nb, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // Test 4: asynchronous reset in the middle of RUN.
        start16 = 1'b1; a16 = 16'h9ABC; b16 = 16'h1234; bin16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4.busy", {31'd0, busy16}, 32'd0);
        check("t4.done", {31'd0, done16}, 32'd0);
        check("t4.d", {16'd0, d16}, 32'd0);
        check("t4.flags", {29'd0, bout16, zero16, ovf16}, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done16 || busy16) ndone++;
            @(negedge clk);
        end
        check("t4.no_done", ndone, 32'd0);
        op16(16'h9ABC, 16'h1234, 1'b0, 1'b0, 16'h0, nb, gd, hk);
        expect16("t4.after", gd, nb, 16'h8888, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Test 5: WIDTH=4 exhaustive against the nibble-adder identity.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); bin4 = ic[0];
                    @(posedge clk);
                    @(negedge clk);
                    start4 = 1'b0;
                    w = 0;
                    while (!done4 && w < 6) begin
                        w++;
                        @(negedge clk);
                    end
                    s = nib_add(4'(ia), ~4'(ib), ~ic[0]);
                    if (ia == 0 && ib == 0 && ic == 0) check("t5.latency", w, 32'd1);
                    check("t5.done", {31'd0, done4}, 32'd1);
                    check("t5.d", {28'd0, d4}, {28'd0, s[3:0]});
                    check("t5.bout", {31'd0, bout4}, {31'd0, ~s[4]});
                end
            end
        end
        @(negedge clk);

        // Test 6: random regression with 0-3 idle cycles between operations.
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
            op16(ra, rb, rbin, 1'b0, 16'h0, nb, gd, hk);
            m  = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            eo = (ra[15] != rb[15]) && (m[15] != ra[15]);
            expect16("t6", gd, nb, m[15:0], m[16], (m[15:0] == 16'd0), eo);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
